pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch-stage sequencer for the pipelined CPU. Owns the program counter, issues instruction-memory requests, and applies the PC+4 increment. Handles redirects from the execute stage (branch/jal/jalr) and back-pressure from the IF/ID register. Sits between the hazard/branch unit, the instruction memory port and the IF/ID pipeline register, and guarantees in-order delivery with no instruction from a squashed path.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high.

Parameters:
- RESET_PC, 32'h0000_3000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, value of if_inst while no valid instruction is held.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- redirect_valid  in  1  EX stage requests PC redirect this cycle
- redirect_target  in  32  new PC; bits [1:0] forced to 0 internally
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request address, stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  response valid this cycle, may stay low for any number of cycles
- imem_rdata  in  32  instruction, sampled only when imem_req & imem_ready
- if_valid  out  1  if_pc/if_inst hold a valid instruction for IF/ID
- if_pc  out  32  PC of if_inst
- if_inst  out  32  fetched instruction
- if_ready  in  1  IF/ID accepts (= !stall_if); transfer when if_valid & if_ready

## Operation
Registers:
- pc: next fetch address.
- req_addr: drives imem_addr.
- Output buffer: if_valid/if_pc/if_inst.
- One hold slot: hold_pc/hold_inst.
- State.

States:
- IDLE: imem_req=0. Entered only from reset. Next state REQ, with req_addr=pc.
- REQ: imem_req=1. On imem_ready with no redirect:
  - Buffer free (if_valid=0 or if_ready=1): buffer ← {req_addr, imem_rdata}, valid=1. pc and req_addr ← req_addr+4. Stay REQ.
  - Buffer full and if_ready=0: hold ← response. pc ← req_addr+4. Go HOLD.
- HOLD: imem_req=0. When if_ready=1: buffer ← hold. req_addr ← pc. Go REQ.
- KILL: imem_req=1 on the stale req_addr. Entered when a redirect arrives while a request is outstanding (state REQ, imem_ready=0). On imem_ready: discard imem_rdata, req_addr ← pc, go REQ.

Redirect (redirect_valid=1) has priority over all non-reset events:
- pc ← {redirect_target[31:2], 2'b00}.
- if_valid ← 0 and hold discarded, even if the same cycle would have transferred or filled them.
- Next state by current state:
  - IDLE, HOLD, or REQ with imem_ready=1 (response discarded): REQ with req_addr=new pc.
  - REQ with imem_ready=0: KILL.
  - KILL: stay KILL; the latest target wins.
- A redirect never changes imem_addr while a request is outstanding.

Buffer consumption: if_valid & if_ready with no refill gives if_valid ← 0. A simultaneous refill and consume keeps if_valid=1 with the new content.

Arithmetic: +4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Reset values:
- State IDLE, pc = req_addr = RESET_PC.
- imem_req=0, imem_addr=RESET_PC.
- if_valid=0, if_pc=RESET_PC, if_inst=NOP_INST.
- Hold slot empty.

Reset applied mid-transaction abandons the outstanding request. The next REQ starts cleanly at RESET_PC.

## Timing
- imem_req/imem_addr are registered-state decodes; there is no combinational path from if_ready or redirect_valid to them.
- Zero-wait memory (imem_ready=1 always), no stalls, with rst low in cycle 0:
  - Cycle 0: IDLE.
  - Cycle 1: REQ of RESET_PC.
  - From cycle 2: if_valid=1, then one instruction per cycle.
- Redirect penalty with zero-wait memory: redirect in cycle N, target requested in N+1, if_valid with if_pc=target in N+2. Wrong-path if_valid is 0 in N+1.
- With W wait cycles: one instruction per W+1 cycles. A redirect during a wait costs the remainder of the current wait plus one full access.
- Back-pressure: at most two instructions are buffered (output plus hold). No request is issued in HOLD.

## Test plan
- Reset, imem_ready=1, if_ready=1:
  - imem_addr sequence is 0x3000, 0x3004, 0x3008.
  - if_valid rises in cycle 2 with if_pc=0x3000.
  - Every instruction is delivered exactly once.
- Stall: if_ready=0 for 5 cycles after 0x3004 appears:
  - 0x3008 is held and imem_req=0 during the stall.
  - On release, 0x3004 then 0x3008 are delivered and the request for 0x300C follows.
  - No loss or duplication.
- Redirect to 0x4002 during a 3-cycle memory wait on 0x3010:
  - imem_addr stays 0x3010 until ready and that response is dropped.
  - Next request is 0x4000; the first if_pc after the redirect is 0x4000.
- Redirect simultaneous with if_ready=0, buffer and hold full:
  - Both are discarded and if_valid=0 next cycle.
  - The target is the next delivered PC.
- Two redirects (0x5000, then 0x6000) in consecutive cycles during a wait:
  - Only 0x6000 is fetched; 0x5000 never appears on imem_addr.
- rst asserted with a request outstanding:
  - All outputs return to reset values next cycle.
  - Fetch restarts at RESET_PC.
  - A late imem_ready is ignored because IDLE does not sample it.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues instruction-memory requests and
// feeds the IF/ID register through a one-entry output buffer plus one hold slot.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        if_ready,
   output logic [1:0]  dbg_state
);

   // Handshakes: imem transfer when imem_req & imem_ready (imem_addr held until
   // then); IF/ID transfer when if_valid & if_ready.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      KILL = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] req_addr, req_addr_nxt;
   logic        buf_valid, buf_valid_nxt;
   logic [31:0] buf_pc, buf_pc_nxt;
   logic [31:0] buf_inst, buf_inst_nxt;
   logic [31:0] hold_pc, hold_pc_nxt;
   logic [31:0] hold_inst, hold_inst_nxt;
   logic [31:0] target_aligned;
   logic [31:0] seq_addr;
   logic        buf_free;

   assign target_aligned = {redirect_target[31:2], 2'b00};
   assign seq_addr       = req_addr + 32'd4;
   assign buf_free       = !buf_valid || if_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         req_addr  <= RESET_PC;
         buf_valid <= 1'b0;
         buf_pc    <= RESET_PC;
         buf_inst  <= NOP_INST;
         hold_pc   <= 32'h0;
         hold_inst <= 32'h0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         req_addr  <= req_addr_nxt;
         buf_valid <= buf_valid_nxt;
         buf_pc    <= buf_pc_nxt;
         buf_inst  <= buf_inst_nxt;
         hold_pc   <= hold_pc_nxt;
         hold_inst <= hold_inst_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      req_addr_nxt  = req_addr;
      buf_valid_nxt = buf_valid;
      buf_pc_nxt    = buf_pc;
      buf_inst_nxt  = buf_inst;
      hold_pc_nxt   = hold_pc;
      hold_inst_nxt = hold_inst;

      // Consumption first; any refill below overrides it.
      if (buf_valid && if_ready) begin
         buf_valid_nxt = 1'b0;
         buf_inst_nxt  = NOP_INST;
      end

      case (state)
         IDLE: begin
            state_nxt    = REQ;
            req_addr_nxt = pc;
         end
         REQ: begin
            if (imem_ready) begin
               pc_nxt = seq_addr;
               if (buf_free) begin
                  buf_valid_nxt = 1'b1;
                  buf_pc_nxt    = req_addr;
                  buf_inst_nxt  = imem_rdata;
                  req_addr_nxt  = seq_addr;
               end else begin
                  hold_pc_nxt   = req_addr;
                  hold_inst_nxt = imem_rdata;
                  state_nxt     = HOLD;
               end
            end
         end
         HOLD: begin
            if (if_ready) begin
               buf_valid_nxt = 1'b1;
               buf_pc_nxt    = hold_pc;
               buf_inst_nxt  = hold_inst;
               req_addr_nxt  = pc;
               state_nxt     = REQ;
            end
         end
         KILL: begin
            if (imem_ready) begin
               req_addr_nxt = pc;
               state_nxt    = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A redirect squashes everything buffered; an in-flight request keeps its
      // address and is drained in KILL.
      if (redirect_valid) begin
         pc_nxt        = target_aligned;
         buf_valid_nxt = 1'b0;
         buf_inst_nxt  = NOP_INST;
         hold_pc_nxt   = hold_pc;
         hold_inst_nxt = hold_inst;
         if (state == KILL || (state == REQ && !imem_ready)) begin
            state_nxt    = KILL;
            req_addr_nxt = req_addr;
         end else begin
            state_nxt    = REQ;
            req_addr_nxt = target_aligned;
         end
      end
   end

   assign imem_req  = (state == REQ) || (state == KILL);
   assign imem_addr = req_addr;
   assign if_valid  = buf_valid;
   assign if_pc     = buf_pc;
   assign if_inst   = buf_inst;
   assign dbg_state = state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the fetch stream.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_ready;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   pc_fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .if_ready(if_ready), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   // Model: a fetch stream with a next-PC, an in-order delivery queue of at most
   // two instructions, and a flag for an in-flight request that must be dropped.
   bit          m_started;
   bit          m_kill;
   logic [31:0] m_stale;
   logic [31:0] m_next;
   logic [63:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [97:0] exp_vec;

   function automatic logic [97:0] obs_vec();
      return {imem_req, imem_req ? imem_addr : 32'h0,
              if_valid, if_valid ? if_pc : 32'h0, if_inst};
   endfunction

   task automatic tick(input logic r, input logic rv, input logic [31:0] tgt,
                       input logic rdy, input logic ifr);
      logic        req;
      logic [31:0] addr;
      logic        e_req;
      logic        e_valid;
      rst = r; redirect_valid = rv; redirect_target = tgt;
      imem_ready = rdy; if_ready = ifr;
      if (!r && if_valid === 1'b1 && ifr) got_q.push_back(if_pc);
      if (r) begin
         m_started = 0; m_kill = 0; m_stale = RESET_PC; m_next = RESET_PC;
         exp_q.delete();
      end else begin
         req  = m_started && (m_kill || exp_q.size() < 2);
         addr = m_kill ? m_stale : m_next;
         if (rv) begin
            exp_q.delete();
            if (m_kill || (req && !rdy)) begin
               m_stale = addr;
               m_kill  = 1;
            end else begin
               m_kill = 0;
            end
            m_next = {tgt[31:2], 2'b00};
         end else begin
            if (exp_q.size() > 0 && ifr) void'(exp_q.pop_front());
            if (req && rdy) begin
               if (m_kill) m_kill = 0;
               else begin
                  exp_q.push_back({m_next, mem_word(m_next)});
                  m_next = m_next + 32'd4;
               end
            end
         end
         m_started = 1;
      end
      @(posedge clk);
      #1;
      e_req   = m_started && (m_kill || exp_q.size() < 2);
      e_valid = exp_q.size() > 0;
      exp_vec = {e_req, e_req ? (m_kill ? m_stale : m_next) : 32'h0,
                 e_valid, e_valid ? exp_q[0][63:32] : 32'h0,
                 e_valid ? exp_q[0][31:0] : NOP_INST};
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      got_q.delete();
   endtask

   task automatic test_reset();
      logic [31:0] ea;
      do_reset();
      n_vec++;
      if ({imem_req, imem_addr, if_valid, if_pc, if_inst} !== {1'b0, RESET_PC, 1'b0, RESET_PC, NOP_INST}) begin
         n_err++;
         $display("FAIL reset_values: got req=%b addr=%h v=%b pc=%h inst=%h", imem_req, imem_addr, if_valid, if_pc, if_inst);
      end
      for (int c = 1; c <= 6; c++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++; $display("FAIL reset_model c%0d: dut=%h model=%h", c, obs_vec(), exp_vec);
         end
         if (c <= 3) begin
            ea = RESET_PC + 32'd4 * 32'(c - 1);
            n_vec++;
            if ({imem_req, imem_addr} !== {1'b1, ea}) begin
               n_err++; $display("FAIL reset_addr_seq c%0d: got %b/%h need 1/%h", c, imem_req, imem_addr, ea);
            end
         end
         ea = (c >= 2) ? RESET_PC + 32'd4 * 32'(c - 2) : 32'h0;
         n_vec++;
         if ({if_valid, (c >= 2) ? if_pc : 32'h0} !== {(c >= 2), ea}) begin
            n_err++; $display("FAIL reset_if_out c%0d: got %b/%h need %b/%h", c, if_valid, if_pc, (c >= 2), ea);
         end
      end
      n_vec++;
      if (got_q.size() != 4 || got_q[0] !== 32'h3000 || got_q[3] !== 32'h300C) begin
         n_err++; $display("FAIL reset_delivery: got %0d items first=%h need 4 from 3000", got_q.size(), got_q.size() > 0 ? got_q[0] : 32'h0);
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++; $display("FAIL stall_model pre%0d: dut=%h model=%h", c, obs_vec(), exp_vec);
         end
      end
      for (int c = 0; c < 5; c++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++; $display("FAIL stall_model s%0d: dut=%h model=%h", c, obs_vec(), exp_vec);
         end
         n_vec++;
         if ({imem_req, if_valid, if_pc} !== {1'b0, 1'b1, 32'h3004}) begin
            n_err++; $display("FAIL stall_hold s%0d: got req=%b v=%b pc=%h need 0/1/3004", c, imem_req, if_valid, if_pc);
         end
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if ({if_valid, if_pc, imem_req, imem_addr} !== {1'b1, 32'h3008, 1'b1, 32'h300C}) begin
         n_err++; $display("FAIL stall_release: got v=%b pc=%h req=%b addr=%h need 1/3008/1/300c", if_valid, if_pc, imem_req, imem_addr);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if (obs_vec() !== exp_vec) begin
         n_err++; $display("FAIL stall_model post: dut=%h model=%h", obs_vec(), exp_vec);
      end
      n_vec++;
      if (got_q.size() != 3 || got_q[0] !== 32'h3000 || got_q[1] !== 32'h3004 || got_q[2] !== 32'h3008) begin
         n_err++; $display("FAIL stall_delivery: got %0d items need 3000,3004,3008", got_q.size());
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      for (int c = 0; c < 5; c++) tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h3010}) begin
         n_err++; $display("FAIL rdw_setup: got %b/%h need 1/3010", imem_req, imem_addr);
      end
      for (int c = 0; c < 3; c++) begin
         tick(1'b0, c == 1, 32'h4002, 1'b0, 1'b1);
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++; $display("FAIL rdw_model w%0d: dut=%h model=%h", c, obs_vec(), exp_vec);
         end
         n_vec++;
         if ({imem_req, imem_addr} !== {1'b1, 32'h3010}) begin
            n_err++; $display("FAIL rdw_addr_stable w%0d: got %b/%h need 1/3010", c, imem_req, imem_addr);
         end
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h4000, 1'b0}) begin
         n_err++; $display("FAIL rdw_next_req: got %b/%h v=%b need 1/4000 v=0", imem_req, imem_addr, if_valid);
      end
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++; $display("FAIL rdw_model d%0d: dut=%h model=%h", k, obs_vec(), exp_vec);
         end
         if (if_valid === 1'b1) break;
      end
      n_vec++;
      if ({if_valid, if_pc} !== {1'b1, 32'h4000}) begin
         n_err++; $display("FAIL rdw_first_pc: got v=%b pc=%h need 1/4000", if_valid, if_pc);
      end
      n_vec++;
      if (got_q.size() != 4 || got_q[3] !== 32'h300C) begin
         n_err++; $display("FAIL rdw_delivery: got %0d items need 4 ending 300c", got_q.size());
      end
   endtask

   task automatic test_redirect_full();
      do_reset();
      for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      n_vec++;
      if ({imem_req, if_valid, if_pc} !== {1'b0, 1'b1, 32'h3000}) begin
         n_err++; $display("FAIL rdf_full: got req=%b v=%b pc=%h need 0/1/3000", imem_req, if_valid, if_pc);
      end
      tick(1'b0, 1'b1, 32'h7000, 1'b1, 1'b0);
      n_vec++;
      if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h7000}) begin
         n_err++; $display("FAIL rdf_flush: got v=%b req=%b addr=%h need 0/1/7000", if_valid, imem_req, imem_addr);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h7000, mem_word(32'h7000)}) begin
         n_err++; $display("FAIL rdf_target: got v=%b pc=%h inst=%h need 1/7000", if_valid, if_pc, if_inst);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if (got_q.size() != 1 || got_q[0] !== 32'h7000) begin
         n_err++; $display("FAIL rdf_delivery: got %0d items need only 7000", got_q.size());
      end
   endtask

   task automatic test_double_redirect();
      bit seen_5000 = 0;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         tick(1'b0, (c == 4) || (c == 5), (c == 4) ? 32'h5000 : 32'h6000, !(c >= 3 && c <= 6), 1'b1);
         if (imem_req === 1'b1 && imem_addr === 32'h5000) seen_5000 = 1;
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++; $display("FAIL dbl_model c%0d: dut=%h model=%h", c, obs_vec(), exp_vec);
         end
         if (c == 7) begin
            n_vec++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h6000}) begin
               n_err++; $display("FAIL dbl_req: got %b/%h need 1/6000", imem_req, imem_addr);
            end
         end
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if ({if_valid, if_pc} !== {1'b1, 32'h6000}) begin
         n_err++; $display("FAIL dbl_first_pc: got v=%b pc=%h need 1/6000", if_valid, if_pc);
      end
      n_vec++;
      if (seen_5000) begin
         n_err++; $display("FAIL dbl_no_5000: got 5000 on imem_addr need never");
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if ({imem_req, imem_addr, if_valid, if_pc, if_inst} !== {1'b0, RESET_PC, 1'b0, RESET_PC, NOP_INST}) begin
         n_err++; $display("FAIL rmid_values: got req=%b addr=%h v=%b pc=%h inst=%h", imem_req, imem_addr, if_valid, if_pc, if_inst);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if ({imem_req, imem_addr, if_valid} !== {1'b1, RESET_PC, 1'b0}) begin
         n_err++; $display("FAIL rmid_restart: got req=%b addr=%h v=%b need 1/3000/0", imem_req, imem_addr, if_valid);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if ({if_valid, if_pc} !== {1'b1, RESET_PC}) begin
         n_err++; $display("FAIL rmid_first_pc: got v=%b pc=%h need 1/3000", if_valid, if_pc);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b1);
      n_vec++;
      if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFF8}) begin
         n_err++; $display("FAIL wrap_align: got %b/%h need 1/fffffff8", imem_req, imem_addr);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if ({imem_addr, if_pc} !== {32'h0, 32'hFFFF_FFFC}) begin
         n_err++; $display("FAIL wrap_addr: got addr=%h pc=%h need 0/fffffffc", imem_addr, if_pc);
      end
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_vec++;
      if (obs_vec() !== exp_vec) begin
         n_err++; $display("FAIL wrap_model: dut=%h model=%h", obs_vec(), exp_vec);
      end
   endtask

   task automatic test_random();
      logic        r, rv, rdy, ifr;
      logic [31:0] tgt;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         r   = ($urandom_range(0, 499) == 0);
         rv  = ($urandom_range(0, 19) == 0);
         tgt = $urandom;
         if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
         rdy = ($urandom_range(0, 9) < 7);
         ifr = ($urandom_range(0, 9) < 6);
         tick(r, rv, tgt, rdy, ifr);
         n_vec++;
         if (obs_vec() !== exp_vec) begin
            n_err++; $display("FAIL random_model c%0d: dut=%h model=%h", c, obs_vec(), exp_vec);
         end
      end
   endtask

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
      imem_ready = 1'b0; if_ready = 1'b0;
      test_reset();
      test_stall();
      test_redirect_wait();
      test_redirect_full();
      test_double_redirect();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
